// File: rtl/ifetch_line_buffer.sv
// ifetch_line_buffer: single 32-byte instruction line buffer serving fetch reads, refilled by 4-beat 64-bit bursts
//   clk, rst                  : clock, synchronous active-high reset
//   mem_read, mem_address     : fetch request (held until mem_resp), byte address
//   mem_rdata, mem_resp       : instruction word and one-cycle response pulse
//   pmem_read, pmem_address   : burst request and line address to physical memory
//   pmem_rdata, pmem_resp     : burst beat data and beat valid
//   hit_count, miss_count     : requests served without a fill, fills started
module ifetch_line_buffer #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_read,
   input  logic [31:0]          mem_address,
   output logic [31:0]          mem_rdata,
   output logic                 mem_resp,
   output logic                 pmem_read,
   output logic [31:0]          pmem_address,
   input  logic [63:0]          pmem_rdata,
   input  logic                 pmem_resp,
   output logic [CNT_WIDTH-1:0] hit_count,
   output logic [CNT_WIDTH-1:0] miss_count
);
   typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;
   state_t       state;
   logic [255:0] line;
   logic [26:0]  tag;
   logic         valid;
   logic         refilled;
   logic [1:0]   cnt;
   logic [31:0]  rdata_q;
   logic [31:2]  req_q;
   logic         hit;
   assign hit = valid && tag == mem_address[31:5];
   // a withdrawn or redirected request gets no pulse; reset also suppresses it
   assign mem_resp = !rst && state == RESP && mem_read && mem_address[31:2] == req_q;
   assign mem_rdata = mem_resp ? rdata_q : '0;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         valid <= 1'b0;
         refilled <= 1'b0;
         cnt <= '0;
         pmem_read <= 1'b0;
         pmem_address <= '0;
         hit_count <= '0;
         miss_count <= '0;
         rdata_q <= '0;
         req_q <= '0;
      end else begin
         refilled <= 1'b0;
         case (state)
            IDLE: if (mem_read) begin
               if (hit) begin
                  rdata_q <= line[{mem_address[4:2], 5'b0} +: 32];
                  req_q <= mem_address[31:2];
                  // the re-check right after a fill answers the miss, not a new hit
                  hit_count <= hit_count + CNT_WIDTH'(!refilled);
                  state <= RESP;
               end else begin
                  pmem_address <= {mem_address[31:5], 5'b0};
                  cnt <= '0;
                  miss_count <= miss_count + CNT_WIDTH'(1);
                  valid <= 1'b0;
                  pmem_read <= 1'b1;
                  state <= FILL;
               end
            end
            FILL: if (pmem_resp) begin
               line[{cnt, 6'b0} +: 64] <= pmem_rdata;
               cnt <= cnt + 2'd1;
               if (cnt == 2'd3) begin
                  valid <= 1'b1;
                  tag <= pmem_address[31:5];
                  pmem_read <= 1'b0;
                  refilled <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ifetch_line_buffer.sv
// tb_ifetch_line_buffer: table vectors, corner sequences and random fetches against a transaction-level model
module tb_ifetch_line_buffer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_read = 1'b0;
   logic [31:0] mem_address = '0;
   logic [31:0] mem_rdata;
   logic        mem_resp;
   logic        pmem_read;
   logic [31:0] pmem_address;
   logic [63:0] pmem_rdata = '0;
   logic        pmem_resp = 1'b0;
   logic [31:0] hit_count;
   logic [31:0] miss_count;
   int          total = 0;
   int          bad = 0;
   int          m_hits = 0;
   int          m_misses = 0;
   logic        m_valid = 1'b0;
   logic [26:0] m_tag = '0;
   typedef struct {logic [31:0] a; logic h; logic [31:0] d;} vec_t;
   vec_t        vt [12];
   logic [31:0] lines [3];
   logic [31:0] ra;
   logic        rh;

   always #5 clk = ~clk;

   ifetch_line_buffer #(.CNT_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_address(mem_address),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp), .pmem_read(pmem_read),
      .pmem_address(pmem_address), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   // memory contents: word w of line ln; line 0x60 holds w*0x11111111
   function automatic logic [31:0] mword(input logic [31:0] ln, input int w);
      return 32'(w) * 32'h1111_1111 + (ln ^ 32'h60);
   endfunction

   function automatic logic [63:0] beat(input logic [31:0] ln, input int k);
      return {mword(ln, 2 * k + 1), mword(ln, 2 * k)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", n, act, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         mem_read = 1'b0;
         pmem_resp = 1'b0;
         @(negedge clk);
         chk("idle_resp", mem_resp, 0);
      end
   endtask

   // one fetch: request, serve any burst with random beat gaps, check timing/data/counters
   task automatic fetch(input logic [31:0] a, input logic eh, input logic [31:0] ed, input int maxgap);
      logic [31:0] ln;
      int beats, last, gap, rc;
      ln = {a[31:5], 5'b0};
      beats = 0;
      last = -1;
      rc = 0;
      gap = int'($urandom_range(0, maxgap));
      tick();
      mem_read = 1'b1;
      mem_address = a;
      pmem_resp = 1'b0;
      @(negedge clk);
      chk("req_resp", mem_resp, 0);
      for (int c = 1; c <= 40 && rc == 0; c++) begin
         tick();
         pmem_resp = 1'b0;
         pmem_rdata = {$urandom, $urandom};
         if (pmem_read && beats < 4) begin
            if (gap == 0) begin
               pmem_resp = 1'b1;
               pmem_rdata = beat(ln, beats);
               beats++;
               if (beats == 4) last = c;
               gap = int'($urandom_range(0, maxgap));
            end else gap--;
         end
         @(negedge clk);
         chk("pmem_read", pmem_read, !eh && (last < 0 || c <= last));
         if (!eh && c == 1) chk("pmem_address", pmem_address, ln);
         if (mem_resp) rc = c;
      end
      pmem_resp = 1'b0;
      if (rc == 0) begin
         total++;
         bad++;
         $display("FAIL timeout: no mem_resp for addr %h", a);
      end else begin
         chk("latency", rc, eh ? 1 : last + 2);
         chk("rdata", mem_rdata, ed);
      end
      m_hits += int'(eh);
      m_misses += int'(!eh);
      chk("hit_count", hit_count, m_hits);
      chk("miss_count", miss_count, m_misses);
      m_valid = 1'b1;
      m_tag = a[31:5];
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt = '{
         '{32'h60,   1'b0, 32'h0000_0000},
         '{32'h64,   1'b1, 32'h1111_1111},
         '{32'h68,   1'b1, 32'h2222_2222},
         '{32'h6C,   1'b1, 32'h3333_3333},
         '{32'h70,   1'b1, 32'h4444_4444},
         '{32'h74,   1'b1, 32'h5555_5555},
         '{32'h78,   1'b1, 32'h6666_6666},
         '{32'h7C,   1'b1, 32'h7777_7777},
         '{32'h63,   1'b1, 32'h0000_0000},
         '{32'h2004, 1'b0, 32'h1111_3171},
         '{32'h2018, 1'b1, 32'h6666_86C6},
         '{32'h7C,   1'b0, 32'h7777_7777}
      };
      lines = '{32'h60, 32'h1000, 32'h7FFF_FFE0};
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mem_resp", mem_resp, 0);
      chk("rst_mem_rdata", mem_rdata, 0);
      chk("rst_pmem_read", pmem_read, 0);
      chk("rst_pmem_address", pmem_address, 0);
      chk("rst_hit_count", hit_count, 0);
      chk("rst_miss_count", miss_count, 0);
      foreach (vt[i]) fetch(vt[i].a, vt[i].h, vt[i].d, 0);
      idle(1);
      // withdrawn request, then redirected request: no pulse, hits stay counted
      tick();
      mem_read = 1'b1;
      mem_address = 32'h68;
      @(negedge clk);
      tick();
      mem_read = 1'b0;
      @(negedge clk);
      chk("mp_drop_resp", mem_resp, 0);
      chk("mp_drop_rdata", mem_rdata, 0);
      tick();
      mem_read = 1'b1;
      mem_address = 32'h6C;
      @(negedge clk);
      tick();
      mem_address = 32'h70;
      @(negedge clk);
      chk("mp_chg_resp", mem_resp, 0);
      m_hits += 2;
      fetch(32'h70, 1'b1, 32'h4444_4444, 0);
      fetch(32'h2000, 1'b0, 32'h0000_2060, 0);
      // mem_read dropped mid-burst: fill still completes and installs the line
      tick();
      mem_read = 1'b1;
      mem_address = 32'h80;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         tick();
         if (k == 2) mem_read = 1'b0;
         pmem_resp = 1'b1;
         pmem_rdata = beat(32'h80, k);
         @(negedge clk);
         chk("drop_pmem_read", pmem_read, 1);
      end
      tick();
      pmem_resp = 1'b0;
      @(negedge clk);
      chk("drop_pmem_read_end", pmem_read, 0);
      chk("drop_no_resp", mem_resp, 0);
      idle(1);
      m_misses++;
      chk("drop_miss_count", miss_count, m_misses);
      fetch(32'h84, 1'b1, 32'h1111_11F1, 0);
      // reset on beat 2: burst abandoned, late beat ignored, line not installed
      tick();
      mem_read = 1'b1;
      mem_address = 32'h60;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         tick();
         pmem_resp = 1'b1;
         pmem_rdata = beat(32'h60, k);
         if (k == 2) begin
            rst = 1'b1;
            mem_read = 1'b0;
         end
         @(negedge clk);
      end
      tick();
      rst = 1'b0;
      pmem_resp = 1'b1;
      pmem_rdata = beat(32'h60, 3);
      @(negedge clk);
      chk("rstfill_pmem_read", pmem_read, 0);
      chk("rstfill_pmem_address", pmem_address, 0);
      chk("rstfill_miss_count", miss_count, 0);
      chk("rstfill_hit_count", hit_count, 0);
      tick();
      pmem_resp = 1'b0;
      @(negedge clk);
      m_hits = 0;
      m_misses = 0;
      fetch(32'h60, 1'b0, 32'h0000_0000, 1);
      // reset while a response is pending: no pulse
      tick();
      mem_read = 1'b1;
      mem_address = 32'h64;
      @(negedge clk);
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("rstresp_resp", mem_resp, 0);
      tick();
      rst = 1'b0;
      mem_read = 1'b0;
      @(negedge clk);
      chk("rstresp_hit_count", hit_count, 0);
      chk("rstresp_pmem_read", pmem_read, 0);
      m_hits = 0;
      m_misses = 0;
      m_valid = 1'b0;
      for (int n = 0; n < 200; n++) begin
         ra = lines[$urandom_range(0, 2)] | {27'h0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
         rh = m_valid && m_tag == ra[31:5];
         fetch(ra, rh, mword({ra[31:5], 5'b0}, int'(ra[4:2])), int'($urandom_range(0, 2)));
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
